// File: rtl/ifetch_if.sv
// Instruction memory read port: one request at a time, held until acknowledged.
interface ifetch_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 32
);
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_rdata
    );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch unit: program counter, memory read handshake with timeout,
// and the instruction register feeding the control FSM.
module ifetch #(
    parameter int unsigned AW       = 16,
    parameter int unsigned DW       = 32,
    parameter int unsigned TIMEOUT  = 15,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          clk,
    input  logic          rst_f,
    input  logic          fetch_en_i,
    input  logic          pc_load_i,
    input  logic [AW-1:0] pc_in_i,
    ifetch_if.master      mem,
    output logic [AW-1:0] pc_o,
    output logic [DW-1:0] ir_o,
    output logic [3:0]    opcode_o,
    output logic [3:0]    mm_o,
    output logic          ir_valid_o,
    output logic          busy_o,
    output logic          fetch_err_o
);

    typedef enum logic [0:0] {StIdle, StReq} state_e;

    // Counter value at which one more unacknowledged edge means abort.
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [DW-1:0] ir_q, ir_d;
    logic          ir_valid_q, ir_valid_d;
    logic          err_q, err_d;
    logic [AW-1:0] pend_q, pend_d;
    logic          pend_vld_q, pend_vld_d;

    // State register; reset takes effect immediately, even mid-request.
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            pc_q       <= AW'(RESET_PC);
            ir_q       <= '0;
            ir_valid_q <= 1'b0;
            err_q      <= 1'b0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            ir_valid_q <= ir_valid_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
        end
    end

    // Next-state logic: fetch sequencing, pc update and deferred loads.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        ir_valid_d = 1'b0;
        err_d      = err_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;

        unique case (state_q)
            StIdle: begin
                pend_vld_d = 1'b0;
                if (pc_load_i) begin
                    pc_d = pc_in_i;
                end
                if (fetch_en_i) begin
                    state_d = StReq;
                    cnt_d   = '0;
                end
            end
            StReq: begin
                // A load on this edge counts as the latest one, even if the fetch ends now.
                if (pc_load_i) begin
                    pend_d     = pc_in_i;
                    pend_vld_d = 1'b1;
                end
                if (mem.mem_ack) begin
                    ir_d       = mem.mem_rdata;
                    pc_d       = pend_vld_d ? pend_d : pc_q + AW'(1);
                    ir_valid_d = 1'b1;
                    pend_vld_d = 1'b0;
                    state_d    = StIdle;
                end else if (cnt_q == TimeoutLast) begin
                    ir_d       = '0;
                    pc_d       = pend_vld_d ? pend_d : pc_q;
                    err_d      = 1'b1;
                    ir_valid_d = 1'b1;
                    pend_vld_d = 1'b0;
                    cnt_d      = cnt_q + 8'd1;
                    state_d    = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs; the address is the live pc, which cannot move while requesting.
    always_comb begin
        mem.mem_req  = (state_q == StReq);
        mem.mem_addr = pc_q;
        busy_o       = (state_q == StReq);
        pc_o         = pc_q;
        ir_o         = ir_q;
        opcode_o     = ir_q[31:28];
        mm_o         = ir_q[27:24];
        ir_valid_o   = ir_valid_q;
        fetch_err_o  = err_q;
    end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch with hand-computed expectations.
module tb_ifetch;

    logic        clk = 1'b0;
    logic        rst_f = 1'b0;
    logic        fetch_en = 1'b0;
    logic        pc_load = 1'b0;
    logic [15:0] pc_in = '0;
    logic [15:0] pc;
    logic [31:0] ir;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic        ir_valid;
    logic        busy;
    logic        fetch_err;

    int checks = 0;
    int failures = 0;

    ifetch_if #(.AW(16), .DW(32)) mem_bus ();

    ifetch #(
        .AW(16), .DW(32), .TIMEOUT(15), .RESET_PC(0)
    ) dut (
        .clk         (clk),
        .rst_f       (rst_f),
        .fetch_en_i  (fetch_en),
        .pc_load_i   (pc_load),
        .pc_in_i     (pc_in),
        .mem         (mem_bus.master),
        .pc_o        (pc),
        .ir_o        (ir),
        .opcode_o    (opcode),
        .mm_o        (mm),
        .ir_valid_o  (ir_valid),
        .busy_o      (busy),
        .fetch_err_o (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        mem_bus.mem_ack   = 1'b0;
        mem_bus.mem_rdata = '0;

        // Reset state.
        #12;
        check("rst_req", 32'(mem_bus.mem_req), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_ir", ir, 32'd0);
        check("rst_err", 32'(fetch_err), 32'd0);
        rst_f = 1'b1;
        tick();

        // Fastest fetch.
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("t1_req", 32'(mem_bus.mem_req), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_addr", 32'(mem_bus.mem_addr), 32'd0);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h1A00_0005;
        tick();
        mem_bus.mem_ack = 1'b0;
        check("t1_ir", ir, 32'h1A00_0005);
        check("t1_opcode", 32'(opcode), 32'd1);
        check("t1_mm", 32'(mm), 32'hA);
        check("t1_pc", 32'(pc), 32'd1);
        check("t1_valid", 32'(ir_valid), 32'd1);
        check("t1_req_low", 32'(mem_bus.mem_req), 32'd0);
        tick();
        check("t1_valid_pulse", 32'(ir_valid), 32'd0);

        // Ack delayed by three wait states.
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("t2_req_wait", 32'(mem_bus.mem_req), 32'd1);
            check("t2_addr_wait", 32'(mem_bus.mem_addr), 32'd1);
            check("t2_ir_hold", ir, 32'h1A00_0005);
            tick();
        end
        check("t2_req_4th", 32'(mem_bus.mem_req), 32'd1);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h2300_0011;
        tick();
        mem_bus.mem_ack = 1'b0;
        check("t2_pc", 32'(pc), 32'd2);
        check("t2_ir", ir, 32'h2300_0011);
        check("t2_valid", 32'(ir_valid), 32'd1);
        check("t2_err", 32'(fetch_err), 32'd0);

        // Timeout abort after exactly 15 request cycles.
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        for (int i = 0; i < 15; i++) begin
            check("t3_req_hold", 32'(mem_bus.mem_req), 32'd1);
            tick();
        end
        check("t3_req_drop", 32'(mem_bus.mem_req), 32'd0);
        check("t3_ir", ir, 32'd0);
        check("t3_pc", 32'(pc), 32'd2);
        check("t3_err", 32'(fetch_err), 32'd1);
        check("t3_valid", 32'(ir_valid), 32'd1);
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h4400_0001;
        tick();
        mem_bus.mem_ack = 1'b0;
        check("t3_pc_after", 32'(pc), 32'd3);
        check("t3_err_sticky", 32'(fetch_err), 32'd1);

        // Mid-request load deferred until completion; two loads, last wins.
        pc_load = 1'b1;
        pc_in   = 16'h0007;
        tick();
        pc_load = 1'b0;
        check("t4_pc7", 32'(pc), 32'd7);
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        pc_load  = 1'b1;
        pc_in    = 16'h0030;
        tick();
        pc_in = 16'h0040;
        tick();
        pc_load = 1'b0;
        check("t4_addr_hold", 32'(mem_bus.mem_addr), 32'd7);
        check("t4_pc_hold", 32'(pc), 32'd7);
        mem_bus.mem_ack = 1'b1;
        tick();
        mem_bus.mem_ack = 1'b0;
        check("t4_pc_loaded", 32'(pc), 32'h40);
        // Another fetch moves pc to 0x41, then load+fetch on one idle edge.
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        mem_bus.mem_ack = 1'b1;
        tick();
        mem_bus.mem_ack = 1'b0;
        check("t4_pc41", 32'(pc), 32'h41);
        fetch_en = 1'b1;
        pc_load  = 1'b1;
        pc_in    = 16'h0040;
        tick();
        fetch_en = 1'b0;
        pc_load  = 1'b0;
        check("t4_same_edge_addr", 32'(mem_bus.mem_addr), 32'h40);
        mem_bus.mem_ack = 1'b1;
        tick();
        mem_bus.mem_ack = 1'b0;
        check("t4_same_edge_pc", 32'(pc), 32'h41);

        // pc wraps from all-ones to zero.
        pc_load = 1'b1;
        pc_in   = 16'hFFFF;
        tick();
        pc_load  = 1'b0;
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        check("t5_addr_ffff", 32'(mem_bus.mem_addr), 32'hFFFF);
        mem_bus.mem_ack = 1'b1;
        tick();
        mem_bus.mem_ack = 1'b0;
        check("t5_pc_wrap", 32'(pc), 32'd0);

        // Reset to clear the sticky error, then ack on the timeout edge.
        rst_f = 1'b0;
        #2;
        rst_f = 1'b1;
        tick();
        check("t5_err_cleared", 32'(fetch_err), 32'd0);
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        check("t5_req_15th", 32'(mem_bus.mem_req), 32'd1);
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h5600_00AB;
        tick();
        mem_bus.mem_ack = 1'b0;
        check("t5_race_ir", ir, 32'h5600_00AB);
        check("t5_race_pc", 32'(pc), 32'd1);
        check("t5_race_err", 32'(fetch_err), 32'd0);
        check("t5_race_valid", 32'(ir_valid), 32'd1);

        // Asynchronous reset during a wait-state request.
        fetch_en = 1'b1;
        tick();
        fetch_en = 1'b0;
        tick();
        tick();
        check("t6_req_before", 32'(mem_bus.mem_req), 32'd1);
        #2;
        rst_f = 1'b0;
        #1;
        check("t6_req_async", 32'(mem_bus.mem_req), 32'd0);
        check("t6_busy_async", 32'(busy), 32'd0);
        check("t6_pc", 32'(pc), 32'd0);
        check("t6_ir", ir, 32'd0);
        check("t6_err", 32'(fetch_err), 32'd0);
        #1;
        rst_f = 1'b1;
        mem_bus.mem_ack   = 1'b1;
        mem_bus.mem_rdata = 32'h7700_0077;
        tick();
        mem_bus.mem_ack = 1'b0;
        check("t6_late_ack_ir", ir, 32'd0);
        check("t6_late_ack_pc", 32'(pc), 32'd0);
        check("t6_late_ack_valid", 32'(ir_valid), 32'd0);
        check("t6_late_ack_req", 32'(mem_bus.mem_req), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
